hamming_encoder26_pipe: RTL and testbench

- Write-path ECC generator for cache storage. Accepts 26-bit data words over a valid/ready stream and emits each word with its 5-bit Hamming check code.
- Output is bit-compatible with the team's 26/5 Hamming decoder.
- Two-stage registered pipeline with full backpressure, throughput of one word per cycle.
- Includes an encoded-word counter. Optional fault injection for exercising the read-path decoder.

---
 rtl/hamming_encoder26_pipe.sv | 93 +++++++++
 tb/tb_hamming_encoder26_pipe.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_encoder26_pipe.sv
// hamming_encoder26_pipe: two-stage valid/ready 26/5 Hamming encoder with handshake counter; optional fault injection under HAMMING_ENC_INJ_EN
module hamming_encoder26_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [25:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [25:0]      out_data,
  output logic [4:0]       out_code,
  output logic [CNT_W-1:0] word_cnt,
  input  logic             cnt_clr,
  input  logic             inj_req,
  input  logic [4:0]       inj_pos,
  output logic             inj_done
);
  function automatic logic [4:0] ecc(input logic [25:0] d);
    return {^(d & 26'h3FFF800), ^(d & 26'h3FC07F0), ^(d & 26'h3C3C78E),
            ^(d & 26'h333366D), ^(d & 26'h2AAAD5B)};
  endfunction
  logic             s1_v_q, s1_v_d, out_valid_q, out_valid_d;
  logic [25:0]      s1_d_q, s1_d_d, out_data_q, out_data_d;
  logic [4:0]       out_code_q, out_code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s2_adv, s1_adv, hs;
  logic [30:0]      flip;
  assign s2_adv    = !out_valid_q || out_ready;
  assign s1_adv    = s1_v_q && s2_adv;
  assign hs        = out_valid_q && out_ready;
  assign in_ready  = !s1_v_q || s2_adv;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_code  = out_code_q;
  assign word_cnt  = cnt_q;
`ifdef HAMMING_ENC_INJ_EN
  logic       armed_q, armed_d, done_q, done_d;
  logic [4:0] pos_q, pos_d;
  assign flip     = (armed_q && pos_q != 5'd31) ? 31'(1) << pos_q : '0;
  assign inj_done = done_q;
  // Arm/overwrite on request; consume on the next S1->S2 transfer
  always_comb begin
    armed_d = inj_req ? 1'b1 : (s1_adv ? 1'b0 : armed_q);
    pos_d   = inj_req ? inj_pos : pos_q;
    done_d  = s1_adv && armed_q;
  end
  // Injection state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
      pos_q   <= 5'd31;
      done_q  <= 1'b0;
    end else begin
      armed_q <= armed_d;
      pos_q   <= pos_d;
      done_q  <= done_d;
    end
  end
`else
  logic unused_inj;
  assign flip       = '0;
  assign inj_done   = 1'b0;
  assign unused_inj = ^{inj_req, inj_pos};
`endif
  // Pipeline advance, code generation and saturating counter
  always_comb begin
    s1_v_d                   = (in_valid && in_ready) ? 1'b1 : (s1_adv ? 1'b0 : s1_v_q);
    s1_d_d                   = (in_valid && in_ready) ? in_data : s1_d_q;
    out_valid_d              = s2_adv ? s1_v_q : out_valid_q;
    {out_code_d, out_data_d} = s1_adv ? ({ecc(s1_d_q), s1_d_q} ^ flip) : {out_code_q, out_data_q};
    cnt_d                    = cnt_clr ? CNT_W'(hs) : (hs && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  // Stage and counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_q      <= 1'b0;
      s1_d_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_code_q  <= '0;
      cnt_q       <= '0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_d_q      <= s1_d_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_code_q  <= out_code_d;
      cnt_q       <= cnt_d;
    end
  end
endmodule

// File: tb/tb_hamming_encoder26_pipe.sv
// tb_hamming_encoder26_pipe: scoreboard bench with a position-based Hamming reference model
module tb_hamming_encoder26_pipe;
  logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, cnt_clr = 0, inj_req = 0;
  logic [25:0] in_data = '0;
  logic [4:0]  inj_pos = 5'd31;
  logic        in_ready, out_valid, inj_done;
  logic [25:0] out_data;
  logic [4:0]  out_code;
  logic [15:0] word_cnt;
  logic [3:0]  word_cnt4;
  logic        unused_ir4, unused_ov4, unused_id4;
  logic [25:0] unused_od4;
  logic [4:0]  unused_oc4;

  hamming_encoder26_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_code(out_code),
    .word_cnt(word_cnt), .cnt_clr(cnt_clr), .inj_req(inj_req), .inj_pos(inj_pos), .inj_done(inj_done));

  hamming_encoder26_pipe #(.CNT_W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(unused_ir4), .in_data(in_data),
    .out_valid(unused_ov4), .out_ready(out_ready), .out_data(unused_od4), .out_code(unused_oc4),
    .word_cnt(word_cnt4), .cnt_clr(cnt_clr), .inj_req(inj_req), .inj_pos(inj_pos), .inj_done(unused_id4));

  always #5 clk = ~clk;

  typedef struct {logic [25:0] d; logic [25:0] orig; logic [4:0] c;} ent_t;
  ent_t        q[$];
  ent_t        e;
  int          pos[26];
  int          checks = 0, fails = 0, cyc = 0;
  int          m16 = 0, m4 = 0, inj_cnt = 0;
  int          phase = 0, acc_cyc = -1, out_first = -1, out_last = -1, dir_idx = 0;
  logic [4:0]  code_tab[5];
  logic        stall_p = 0, hs, pend = 0;
  logic [30:0] stall_v;
  logic [25:0] pend_d = '0;
  logic [4:0]  pend_c = '0;

  // Check bits are the XOR of the Hamming positions of every set data bit
  function automatic logic [4:0] enc(input logic [25:0] d);
    logic [4:0] c = '0;
    for (int i = 0; i < 26; i++) if (d[i]) c ^= 5'(pos[i]);
    return c;
  endfunction

  function automatic logic [25:0] dec(input logic [25:0] d, input logic [4:0] c);
    logic [4:0]  s = enc(d) ^ c;
    logic [25:0] r = d;
    for (int i = 0; i < 26; i++) if (pos[i] == int'(s)) r[i] = ~r[i];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, a, x);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: sampled mid-cycle, predicts what the next rising edge does
  always @(negedge clk) begin
    hs = out_valid && out_ready;
    chk("word_cnt", 32'(word_cnt), 32'(m16));
    chk("word_cnt4", 32'(word_cnt4), 32'(m4));
    if (inj_done === 1'b1) inj_cnt++;
    if (stall_p) chk("stall_hold", {1'b0, out_data, out_code}, {1'b0, stall_v});
    stall_p = rst_n && out_valid && !out_ready;
    stall_v = {out_data, out_code};
    if (!rst_n) begin
      q.delete();
      m16 = 0;
      m4 = 0;
    end else begin
      if (hs) begin
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL stale_out: got %0h expected no word", out_data);
        end else begin
          e = q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.d));
          chk("out_code", 32'(out_code), 32'(e.c));
          chk("decode", 32'(dec(out_data, out_code)), 32'(e.orig));
          if (phase == 1 && dir_idx < 5) begin
            if (out_first < 0) out_first = cyc;
            out_last = cyc;
            chk("dir_code", 32'(out_code), 32'(code_tab[dir_idx]));
            dir_idx++;
          end
        end
      end
      if (in_valid && in_ready) begin
        e.orig = in_data;
        e.d = in_data;
        e.c = enc(in_data);
`ifdef HAMMING_ENC_INJ_EN
        if (pend) begin
          e.d ^= pend_d;
          e.c ^= pend_c;
          pend = 0;
        end
`endif
        q.push_back(e);
        if (phase == 1 && acc_cyc < 0) acc_cyc = cyc;
      end
      m16 = cnt_clr ? int'(hs) : (hs && m16 < 65535) ? m16 + 1 : m16;
      m4  = cnt_clr ? int'(hs) : (hs && m4 < 15) ? m4 + 1 : m4;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    in_valid = 0;
    out_ready = 1;
    for (int k = 0; k < 20 && q.size() != 0; k++) tick();
    chk("drain", 32'(q.size()), 32'd0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, sent;
    logic pending, acc;
    logic [25:0] w[5];
    logic [4:0] ipos[2];
    p = 2;
    for (int i = 0; i < 26; i++) begin
      p++;
      while ((p & (p - 1)) == 0) p++;
      pos[i] = p;
    end
    w = '{26'h0000000, 26'h0000001, 26'h0000010, 26'h2000000, 26'h3FFFFFF};
    code_tab = '{5'b00000, 5'b00011, 5'b01001, 5'b11111, 5'b11111};
    ipos = '{5'd5, 5'd27};
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_code", 32'(out_code), 32'd0);
    chk("rst_inj_done", 32'(inj_done), 32'd0);
    rst_n = 1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1;
    phase = 1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1;
      in_data = w[i];
      tick();
    end
    in_valid = 0;
    repeat (8) tick();
    phase = 0;
    chk("dir_count", 32'(dir_idx), 32'd5);
    chk("latency", 32'(out_first - acc_cyc), 32'd2);
    chk("throughput", 32'(out_last - out_first), 32'd4);
    out_ready = 0;
    in_valid = 1;
    in_data = 26'h1234567;
    tick();
    in_data = 26'h0ABCDEF;
    tick();
    in_data = 26'h3000001;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    repeat (4) tick();
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    tick();
    drain();
    sent = 0;
    pending = 0;
    for (int c = 0; c < 60000 && sent < 10000; c++) begin
      out_ready = ($urandom % 10) < 7;
      cnt_clr = ($urandom % 500) == 0;
      if (!pending) begin
        in_valid = ($urandom % 10) < 7;
        in_data = 26'($urandom);
      end
      #1;
      acc = in_valid && in_ready;
      if (acc) sent++;
      pending = in_valid && !acc;
      tick();
    end
    cnt_clr = 0;
    chk("rand_sent", 32'(sent), 32'd10000);
    drain();
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    in_valid = 1;
    for (int i = 0; i < 20; i++) begin
      in_data = 26'($urandom);
      tick();
    end
    in_valid = 0;
    repeat (4) tick();
    chk("sat_cnt4", 32'(word_cnt4), 32'd15);
    chk("cnt16_20", 32'(word_cnt), 32'd20);
    in_valid = 1;
    repeat (3) tick();
    in_valid = 0;
    cnt_clr = 1;
    #1;
    chk("clr_hs_valid", 32'(out_valid), 32'd1);
    tick();
    cnt_clr = 0;
    chk("clr_hs_cnt4", 32'(word_cnt4), 32'd1);
    chk("clr_hs_cnt16", 32'(word_cnt), 32'd1);
    drain();
    out_ready = 0;
    in_valid = 1;
    in_data = 26'h2AAAAAA;
    tick();
    in_data = 26'h1555555;
    tick();
    in_valid = 0;
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_word_cnt", 32'(word_cnt), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1;
    repeat (5) tick();
    chk("midrst_no_stale", 32'(out_valid), 32'd0);
    for (int j = 0; j < 2; j++) begin
      inj_req = 1;
      inj_pos = ipos[j];
`ifdef HAMMING_ENC_INJ_EN
      pend = 1;
      pend_d = ipos[j] < 26 ? 26'(1) << ipos[j] : '0;
      pend_c = ipos[j] >= 26 ? 5'(1) << (ipos[j] - 5'd26) : '0;
`endif
      tick();
      inj_req = 0;
      inj_pos = 5'd31;
      in_valid = 1;
      in_data = 26'h0000000;
      tick();
      in_data = 26'h0000000;
      tick();
      in_valid = 0;
`ifdef HAMMING_ENC_INJ_EN
      chk("inj_word", {1'b0, out_data, out_code}, j == 0 ? 31'h20 << 5 : 31'b00010);
`else
      chk("inj_word", {1'b0, out_data, out_code}, 32'd0);
`endif
      drain();
    end
`ifdef HAMMING_ENC_INJ_EN
    chk("inj_done_pulses", 32'(inj_cnt), 32'd2);
`else
    chk("inj_done_pulses", 32'(inj_cnt), 32'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
